// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer
//   Multi-cycle run controller around the single-cycle core. It performs the
//   start/ack handshake, picks one of three program entry addresses, gates PC
//   advance and architectural writes, stretches LOADs for a slow data memory,
//   detects HALT and counts the cycles spent executing.
//
//   Optional feature: define CPU_SEQ_WATCHDOG_EN to end a run that reaches
//   WDOG_LIMIT cycles. The run then ends with timeout=1. Without the macro,
//   timeout is tied to 0 and cycle_count simply saturates.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        synchronous, active-high reset
//   start        run request (level)
//   prog_sel     program select, sampled with start (3 selects program 0)
//   halt         HALT decode of the current instruction
//   mem_read     LOAD decode of the current instruction
//   pc_load      fetch unit loads start_addr this cycle (registered)
//   start_addr   entry address for pc_load (registered)
//   pc_en        fetch unit may advance this edge (combinational)
//   wr_en        qualifies register-file / data-memory writes (combinational)
//   busy         program in progress (registered)
//   ack          program finished (registered)
//   timeout      run ended by the watchdog (registered)
//   cycle_count  cycles of the last or current run (registered, saturating)
module cpu_run_sequencer #(
  parameter int PC_W        = 10,
  parameter int CNT_W       = 16,
  parameter int MEM_LAT     = 1,
  parameter int START_ADDR0 = 0,
  parameter int START_ADDR1 = 256,
  parameter int START_ADDR2 = 512,
  parameter int WDOG_LIMIT  = 4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             halt,
  input  logic             mem_read,
  output logic             pc_load,
  output logic [PC_W-1:0]  start_addr,
  output logic             pc_en,
  output logic             wr_en,
  output logic             busy,
  output logic             ack,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_STALL,
    S_DONE
  } state_t;

  // A LOAD only enters STALL when the memory needs extra cycles.
  localparam bit LOAD_STALLS = (MEM_LAT > 0);
  localparam int WAIT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  // The RUN cycle that decodes the LOAD is the first of its 1+MEM_LAT cycles,
  // so STALL waits MEM_LAT-1 cycles before the commit cycle.
  localparam logic [WAIT_W-1:0] WAIT_INIT =
    (MEM_LAT > 0) ? WAIT_W'(MEM_LAT - 1) : '0;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              running;
  logic              wdog_hit;
  logic [CNT_W-1:0]  cnt_inc;

  assign running = (state == S_RUN) || (state == S_STALL);
  assign cnt_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

  function automatic logic [PC_W-1:0] entry_addr(input logic [1:0] sel);
    case (sel)
      2'd1:    return PC_W'(START_ADDR1);
      2'd2:    return PC_W'(START_ADDR2);
      default: return PC_W'(START_ADDR0);
    endcase
  endfunction

`ifdef CPU_SEQ_WATCHDOG_EN
  assign wdog_hit = running && (cycle_count == CNT_W'(WDOG_LIMIT));

  always_ff @(posedge clk) begin
    if (reset)
      timeout <= 1'b0;
    else if (state == S_INIT)
      timeout <= 1'b0;
    else if (wdog_hit)
      timeout <= 1'b1;
  end
`else
  logic wdog_unused;
  assign wdog_unused = ^WDOG_LIMIT;
  assign wdog_hit    = 1'b0;
  assign timeout     = 1'b0;
`endif

  // PC advance and write qualification follow the current instruction in the
  // same cycle; reset overrides everything.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_en = 1'b0;
    if (!reset && !wdog_hit) begin
      case (state)
        S_RUN:   pc_en = !halt && !(mem_read && LOAD_STALLS);
        S_STALL: pc_en = (wait_cnt == '0);
        default: pc_en = 1'b0;
      endcase
    end
    wr_en = pc_en;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      pc_load     <= 1'b0;
      start_addr  <= '0;
      busy        <= 1'b0;
      ack         <= 1'b0;
      cycle_count <= '0;
    end else begin
      pc_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_INIT;
            start_addr <= entry_addr(prog_sel);
            pc_load    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_INIT: begin
          state       <= S_RUN;
          cycle_count <= '0;
        end
        S_RUN: begin
          if (wdog_hit) begin
            // Count is left at the limit so it reads WDOG_LIMIT in DONE.
            state <= S_DONE;
            busy  <= 1'b0;
            ack   <= 1'b1;
          end else begin
            cycle_count <= cnt_inc;
            if (halt) begin
              state <= S_DONE;
              busy  <= 1'b0;
              ack   <= 1'b1;
            end else if (mem_read && LOAD_STALLS) begin
              state    <= S_STALL;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_STALL: begin
          if (wdog_hit) begin
            state <= S_DONE;
            busy  <= 1'b0;
            ack   <= 1'b1;
          end else begin
            cycle_count <= cnt_inc;
            if (wait_cnt == '0)
              state <= S_RUN;
            else
              wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        S_DONE: begin
          // A new run needs start to drop first.
          if (!start) begin
            state <= S_IDLE;
            ack   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Testbench for cpu_run_sequencer. Each run is described at instruction level
// (launch, ALU, LOAD, HALT, handshake release); those steps expand into a
// per-cycle table of inputs and expected outputs, which one loop then applies
// and compares every cycle.
module tb_cpu_run_sequencer;

  localparam int PC_W    = 10;
  localparam int CNT_W   = 16;
  localparam int MEM_LAT = 2;
  localparam int WDOG    = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       prog_sel = 2'd0;
  logic             halt = 1'b0;
  logic             mem_read = 1'b0;
  logic             pc_load;
  logic [PC_W-1:0]  start_addr;
  logic             pc_en;
  logic             wr_en;
  logic             busy;
  logic             ack;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  always #5 clk = ~clk;

  cpu_run_sequencer #(
    .PC_W(PC_W), .CNT_W(CNT_W), .MEM_LAT(MEM_LAT),
    .START_ADDR0(0), .START_ADDR1(256), .START_ADDR2(512),
    .WDOG_LIMIT(WDOG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
    .halt(halt), .mem_read(mem_read), .pc_load(pc_load),
    .start_addr(start_addr), .pc_en(pc_en), .wr_en(wr_en), .busy(busy),
    .ack(ack), .timeout(timeout), .cycle_count(cycle_count)
  );

  typedef struct {
    bit       rst;
    bit       st;
    bit [1:0] sel;
    bit       h;
    bit       mr;
    bit       chk_regs;
    bit       pl;
    bit       en;
    bit       bsy;
    bit       ak;
    bit       tmo;
    int       addr;
    int       cnt;
    int       lit_cnt;
    int       lit_addr;
  } cyc_t;

  cyc_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_idx  = 0;

  // Model state: what the registered outputs hold between runs.
  int   m_cnt  = 0;
  int   m_addr = 0;
  bit   m_tmo  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_idx, act, exp);
    end
  endtask

  function automatic int entry(input bit [1:0] s);
    case (s)
      2'd1:    return 256;
      2'd2:    return 512;
      default: return 0;
    endcase
  endfunction

  task automatic add(input bit rst, input bit st, input bit [1:0] sel,
                     input bit h, input bit mr, input bit chk,
                     input bit pl, input bit en, input bit bsy, input bit ak);
    cyc_t c;
    c.rst = rst; c.st = st; c.sel = sel; c.h = h; c.mr = mr;
    c.chk_regs = chk; c.pl = pl; c.en = en; c.bsy = bsy; c.ak = ak;
    c.tmo = m_tmo; c.addr = m_addr; c.cnt = m_cnt;
    c.lit_cnt = -1; c.lit_addr = -1;
    q.push_back(c);
  endtask

  task automatic pin_last(input int lit_cnt, input int lit_addr);
    q[q.size()-1].lit_cnt  = lit_cnt;
    q[q.size()-1].lit_addr = lit_addr;
  endtask

  // Start request seen in IDLE, then the one-cycle entry-load cycle.
  task automatic launch(input bit [1:0] s, input bit hold);
    add(0, 1, s, 0, 0, 1, 0, 0, 0, 0);
    m_addr = entry(s);
    add(0, hold, 2'd0, 0, 0, 1, 1, 0, 1, 0);
    m_cnt = 0;
    m_tmo = 1'b0;
  endtask

  task automatic alu(input bit hold);
    add(0, hold, 2'd0, 0, 0, 1, 0, 1, 1, 0);
    m_cnt++;
  endtask

  // A LOAD occupies 1+MEM_LAT cycles and only commits in the last one.
  task automatic load(input bit hold);
    for (int i = 0; i <= MEM_LAT; i++) begin
      add(0, hold, 2'd0, 0, 1, 1, 0, (i == MEM_LAT), 1, 0);
      m_cnt++;
    end
  endtask

  task automatic halt_op(input bit hold);
    add(0, hold, 2'd0, 1, 0, 1, 0, 0, 1, 0);
    m_cnt++;
  endtask

  // Finished: ack with start still held for extra_hold cycles, then start
  // drops, then two idle cycles in which nothing relaunches.
  task automatic finish_run(input int extra_hold);
    for (int i = 0; i < extra_hold; i++)
      add(0, 1, 2'd0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic build;
    // Reset for two cycles with start high: no launch, outputs cleared.
    add(1, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 2'd1, 0, 0, 1, 0, 0, 0, 0);
    pin_last(0, 0);
    add(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0);

    // Basic run, program 1: four ALU ops then HALT.
    launch(2'd1, 0);
    pin_last(-1, 256);
    for (int i = 0; i < 4; i++) alu(0);
    halt_op(0);
    finish_run(0);
    q[q.size()-3].lit_cnt = 5;

    // LOAD stall run, program 0.
    launch(2'd0, 0);
    pin_last(-1, 0);
    alu(0);
    load(0);
    alu(0);
    halt_op(0);
    finish_run(0);
    q[q.size()-3].lit_cnt = 6;

    // Handshake hold, program 2: start held through HALT and three more cycles.
    launch(2'd2, 1);
    pin_last(-1, 512);
    alu(1);
    alu(1);
    halt_op(1);
    finish_run(3);
    q[q.size()-3].lit_cnt = 3;

    // Select 3 maps to program 0 (address changes from 512).
    launch(2'd3, 0);
    pin_last(-1, 0);
    halt_op(0);
    finish_run(0);

    // Reset in the LOAD commit cycle of a program-1 run: enables forced low.
    launch(2'd1, 0);
    alu(0);
    for (int i = 0; i < MEM_LAT; i++) begin
      add(0, 0, 2'd0, 0, 1, 1, 0, 0, 1, 0);
      m_cnt++;
    end
    add(1, 0, 2'd0, 0, 1, 1, 0, 0, 1, 0);
    m_cnt = 0; m_addr = 0; m_tmo = 1'b0;
    add(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0);
    pin_last(0, 0);
    launch(2'd3, 0);
    pin_last(-1, 0);
    alu(0);
    halt_op(0);
    finish_run(0);

`ifdef CPU_SEQ_WATCHDOG_EN
    // Watchdog: no HALT until the limit; HALT in the limit cycle loses.
    launch(2'd1, 0);
    while (m_cnt < WDOG) alu(0);
    add(0, 0, 2'd0, 1, 0, 1, 0, 0, 1, 0);
    m_tmo = 1'b1;
    finish_run(0);
    q[q.size()-3].lit_cnt = 10;
    // Timeout still visible during the next entry cycle, then cleared.
    launch(2'd2, 0);
    halt_op(0);
    finish_run(0);
`endif
  endtask

  initial begin
    build();
    foreach (q[i]) begin
      cyc_idx = i;
      @(posedge clk);
      #1;
      reset    = q[i].rst;
      start    = q[i].st;
      prog_sel = q[i].sel;
      halt     = q[i].h;
      mem_read = q[i].mr;
      @(negedge clk);
      check("pc_en", {31'd0, pc_en}, {31'd0, q[i].en});
      check("wr_en", {31'd0, wr_en}, {31'd0, q[i].en});
      if (q[i].chk_regs) begin
        check("pc_load",     {31'd0, pc_load}, {31'd0, q[i].pl});
        check("busy",        {31'd0, busy},    {31'd0, q[i].bsy});
        check("ack",         {31'd0, ack},     {31'd0, q[i].ak});
        check("timeout",     {31'd0, timeout}, {31'd0, q[i].tmo});
        check("start_addr",  32'(start_addr),  32'(q[i].addr));
        check("cycle_count", 32'(cycle_count), 32'(q[i].cnt & 32'hFFFF));
      end
      if (q[i].lit_cnt >= 0)
        check("lit_cycle_count", 32'(cycle_count), 32'(q[i].lit_cnt));
      if (q[i].lit_addr >= 0)
        check("lit_start_addr", 32'(start_addr), 32'(q[i].lit_addr));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
